// File: rtl/rv32i_types.sv
// Shared cache types: default cache line width and the cache controller state encoding.
package rv32i_types;

  localparam int unsigned CACHELINE_W = 256;

  typedef logic [CACHELINE_W-1:0] cacheline_t;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2
  } cache_state_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: heap-indexed nodes (node n stored at bit n-1),
// a 0 bit steers the victim walk toward the lower-way subtree.
module plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         plru_i,
  input  logic [$clog2(WAYS)-1:0] access_way_i,
  output logic [$clog2(WAYS)-1:0] victim_o,
  output logic [WAYS-2:0]         plru_next_o
);

  localparam int unsigned LVLS = $clog2(WAYS);

  int unsigned vnode;
  int unsigned unode;
  logic        vbit;
  logic        dir;

  // Follow the node bits from the root down to a leaf.
  always_comb begin
    vnode = 1;
    vbit  = 1'b0;
    for (int l = 0; l < LVLS; l++) begin
      vbit = 1'b0;
      for (int k = 1; k < WAYS; k++) begin
        if (vnode == k) vbit = plru_i[k-1];
      end
      vnode = 2 * vnode + {31'b0, vbit};
    end
    victim_o = LVLS'(vnode - WAYS);
  end

  // Point every node on the accessed way's path away from it.
  always_comb begin
    plru_next_o = plru_i;
    unode       = 1;
    dir         = 1'b0;
    for (int l = 0; l < LVLS; l++) begin
      dir = access_way_i[LVLS-1-l];
      for (int k = 1; k < WAYS; k++) begin
        if (unode == k) plru_next_o[k-1] = ~dir;
      end
      unode = 2 * unode + {31'b0, dir};
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with tree-PLRU replacement.
// Define CACHE_PERF_CNT_EN to build the hit/miss performance counters.
module cache_nway
  import rv32i_types::*;
#(
  parameter int unsigned S_OFFSET = 5,
  parameter int unsigned S_INDEX  = 4,
  parameter int unsigned WAYS     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  mem_address,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [2**S_OFFSET-1:0]       mem_byte_enable256,
  input  logic [8*(2**S_OFFSET)-1:0]   mem_wdata256,
  output logic [8*(2**S_OFFSET)-1:0]   mem_rdata256,
  output logic                         mem_resp,
  output logic [31:0]                  pmem_address,
  output logic                         pmem_read,
  output logic                         pmem_write,
  output logic [8*(2**S_OFFSET)-1:0]   pmem_wdata,
  input  logic [8*(2**S_OFFSET)-1:0]   pmem_rdata,
  input  logic                         pmem_resp,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);

  localparam int unsigned BYTES  = 2**S_OFFSET;
  localparam int unsigned LINE_W = 8 * BYTES;
  localparam int unsigned SETS   = 2**S_INDEX;
  localparam int unsigned TAG_W  = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned WAY_W  = $clog2(WAYS);

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAYS-2:0]   plru_q  [SETS];

  cache_state_e      state_q;
  logic [WAY_W-1:0]  victim_q;

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] idx;
  logic               req;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic               has_inv;
  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   plru_victim;
  logic [WAY_W-1:0]   miss_victim;
  logic [WAYS-2:0]    plru_next;
  logic               check_hit;
  logic [LINE_W-1:0]  hit_line;
  logic [LINE_W-1:0]  merged_line;

  assign req_tag = mem_address[31 -: TAG_W];
  assign idx     = mem_address[S_OFFSET+S_INDEX-1 -: S_INDEX];
  assign req     = mem_read | mem_write;

  // Tag compare and lowest-index invalid way for the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !has_inv) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  plru_tree #(
    .WAYS (WAYS)
  ) u_plru (
    .plru_i       (plru_q[idx]),
    .access_way_i (hit_way),
    .victim_o     (plru_victim),
    .plru_next_o  (plru_next)
  );

  assign miss_victim = has_inv ? inv_way : plru_victim;
  assign check_hit   = (state_q == CHECK) && req && hit;
  assign hit_line    = data_q[idx][hit_way];

  // Byte-masked merge of the CPU write into the hit line.
  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < BYTES; b++) begin
      if (mem_byte_enable256[b]) merged_line[8*b +: 8] = mem_wdata256[8*b +: 8];
    end
  end

  assign mem_resp     = check_hit;
  assign mem_rdata256 = hit_line;
  assign pmem_read    = (state_q == ALLOC);
  assign pmem_write   = (state_q == WB);
  assign pmem_wdata   = data_q[idx][victim_q];
  assign pmem_address = (state_q == WB) ? {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}}
                                        : {req_tag, idx, {S_OFFSET{1'b0}}};

  // Controller: state, victim register and per-set valid/dirty/PLRU bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      unique case (state_q)
        CHECK: begin
          if (req) begin
            if (hit) begin
              plru_q[idx] <= plru_next;
              if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
            end else begin
              victim_q <= miss_victim;
              state_q  <= (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim]) ? WB : ALLOC;
            end
          end
        end
        WB: begin
          if (pmem_resp) state_q <= ALLOC;
        end
        ALLOC: begin
          if (pmem_resp) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            state_q                <= CHECK;
          end
        end
        default: state_q <= CHECK;
      endcase
    end
  end

  // Tag and data storage; contents are qualified by valid so no reset.
  always_ff @(posedge clk) begin
    if ((state_q == ALLOC) && pmem_resp) begin
      tag_q[idx][victim_q]  <= req_tag;
      data_q[idx][victim_q] <= pmem_rdata;
    end else if (check_hit && mem_write) begin
      data_q[idx][hit_way] <= merged_line;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        refill_q;
  logic        check_miss;

  assign check_miss = (state_q == CHECK) && req && !hit;

  // refill_q marks the completion that follows a fill so it is not scored as a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      if ((state_q == ALLOC) && pmem_resp) refill_q <= 1'b1;
      else if (check_hit)                  refill_q <= 1'b0;
      if (check_hit && !refill_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (check_miss)             miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed self-checking bench for cache_nway: 4-way default build plus an 8-way instance.
module tb_cache_nway;

  typedef logic [255:0] line_t;

`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-way instance
  logic [31:0] mem_address = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_byte_enable256 = '0;
  line_t       mem_wdata256 = '0, mem_rdata256;
  logic        mem_resp;
  logic [31:0] pmem_address;
  logic        pmem_read, pmem_write;
  line_t       pmem_wdata, pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
  logic [31:0] hit_count, miss_count;

  // 8-way instance
  logic [31:0] e_address = '0;
  logic        e_read = 1'b0;
  line_t       e_rdata, e_pwdata, e_prdata = '0;
  logic        e_resp, e_pread, e_pwrite, e_presp = 1'b0;
  logic [31:0] e_paddr, e_hits, e_misses;

  int checks = 0;
  int errors = 0;
  int exp_h  = 0;
  int exp_m  = 0;

  cache_nway dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_wdata256(mem_wdata256), .mem_rdata256(mem_rdata256),
    .mem_resp(mem_resp), .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_nway #(.WAYS(8)) dut8 (
    .clk(clk), .rst(rst), .mem_address(e_address), .mem_read(e_read), .mem_write(1'b0),
    .mem_byte_enable256(32'h0), .mem_wdata256(256'h0), .mem_rdata256(e_rdata),
    .mem_resp(e_resp), .pmem_address(e_paddr), .pmem_read(e_pread), .pmem_write(e_pwrite),
    .pmem_wdata(e_pwdata), .pmem_rdata(e_prdata), .pmem_resp(e_presp),
    .hit_count(e_hits), .miss_count(e_misses)
  );

  function automatic line_t mem_line(input logic [31:0] a);
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = {a[23:0], 8'(i)};
    return l;
  endfunction

  task automatic chk(input string tag, input line_t obs, input line_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_hits"},   256'(hit_count),  PERF ? 256'(exp_h) : 256'(0));
    chk({tag, "_misses"}, 256'(miss_count), PERF ? 256'(exp_m) : 256'(0));
  endtask

  // One CPU request on the 4-way cache, with a 1-cycle memory responder. Entered at a negedge.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] be,
                        input line_t wd, input bit exp_hit, output line_t rd,
                        output int n_wb, output int n_rd, output logic [31:0] wb_addr,
                        output line_t wb_data, output logic [31:0] rd_addr, output bit wb_first);
    int cyc;
    bit done;
    bit excl_bad;
    n_wb = 0; n_rd = 0; wb_addr = '0; wb_data = '0; rd_addr = '0; rd = '0; wb_first = 1'b0;
    cyc = 0; done = 1'b0; excl_bad = 1'b0;
    mem_address = addr; mem_read = !wr; mem_write = wr;
    mem_byte_enable256 = be; mem_wdata256 = wd;
    while (!done && cyc < 40) begin
      #1;
      if ((mem_resp && pmem_read) || (mem_resp && pmem_write) || (pmem_read && pmem_write))
        excl_bad = 1'b1;
      if (mem_resp) begin
        rd = mem_rdata256;
        done = 1'b1;
      end else if (pmem_write) begin
        n_wb++;
        if (n_rd == 0) wb_first = 1'b1;
        wb_addr = pmem_address; wb_data = pmem_wdata; pmem_resp = 1'b1;
      end else if (pmem_read) begin
        n_rd++;
        rd_addr = pmem_address; pmem_rdata = mem_line(pmem_address); pmem_resp = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!done) cyc++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    chk("completed", 256'(done), 256'(1));
    chk("exclusive", 256'(excl_bad), 256'(0));
    chk("hit_latency", 256'(cyc == 0), 256'(exp_hit));
    if (exp_hit) exp_h++; else exp_m++;
  endtask

  task automatic access8(input logic [31:0] addr, output int n_rd, output int n_wb,
                         output logic [31:0] rd_addr, output bit hit);
    int cyc;
    bit done;
    n_rd = 0; n_wb = 0; rd_addr = '0; cyc = 0; done = 1'b0;
    e_address = addr; e_read = 1'b1;
    while (!done && cyc < 40) begin
      #1;
      if (e_resp) done = 1'b1;
      else if (e_pwrite) begin
        n_wb++; e_presp = 1'b1;
      end else if (e_pread) begin
        n_rd++; rd_addr = e_paddr; e_prdata = mem_line(e_paddr); e_presp = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      e_presp = 1'b0;
      if (!done) cyc++;
    end
    e_read = 1'b0;
    hit = done && (cyc == 0);
    chk("e_completed", 256'(done), 256'(1));
  endtask

  initial begin
    line_t rd, wbd, merged;
    int n_wb, n_rd, cyc;
    logic [31:0] wba, rda;
    bit wbf, hit8;
    line_t d = {8{32'hCAFE_F00D}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_mem_resp", 256'(mem_resp), 256'(0));
    chk("reset_pmem_read", 256'(pmem_read), 256'(0));
    chk("reset_pmem_write", 256'(pmem_write), 256'(0));
    chk_counters("reset");
    @(negedge clk);

    // Cold read miss then fill
    access(1'b0, 32'h40, '0, '0, 1'b0, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("cold_nwb", 256'(n_wb), 256'(0));
    chk("cold_nrd", 256'(n_rd), 256'(1));
    chk("cold_rdaddr", 256'(rda), 256'(32'h40));
    chk("cold_rdata", rd, mem_line(32'h40));
    chk_counters("cold");

    // Byte-masked write hit, then read back
    access(1'b1, 32'h40, 32'h0000_000F, d, 1'b1, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    merged = mem_line(32'h40);
    merged[31:0] = 32'hCAFE_F00D;
    access(1'b0, 32'h40, '0, '0, 1'b1, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("merge_rdata", rd, merged);
    chk_counters("merge");

    // Fill the remaining ways of set 2
    for (int t = 1; t < 4; t++) begin
      access(1'b0, 32'h40 + 32'(t) * 32'h200, '0, '0, 1'b0, rd, n_wb, n_rd, wba, wbd, rda, wbf);
      chk("fill_nwb", 256'(n_wb), 256'(0));
      chk("fill_rdata", rd, mem_line(32'h40 + 32'(t) * 32'h200));
    end
    access(1'b0, 32'h40, '0, '0, 1'b1, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("rehit_rdata", rd, merged);

    // PLRU picks way 2 (0x440, clean)
    access(1'b0, 32'h840, '0, '0, 1'b0, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("plru_nwb", 256'(n_wb), 256'(0));
    chk("plru_rdaddr", 256'(rda), 256'(32'h840));
    access(1'b0, 32'h240, '0, '0, 1'b1, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("keep240_rdata", rd, mem_line(32'h240));
    access(1'b0, 32'h640, '0, '0, 1'b1, rd, n_wb, n_rd, wba, wbd, rda, wbf);

    // Dirty victim 0x40: write-back precedes the fill
    access(1'b0, 32'hA40, '0, '0, 1'b0, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("wb_count", 256'(n_wb), 256'(1));
    chk("wb_addr", 256'(wba), 256'(32'h40));
    chk("wb_data", wbd, merged);
    chk("wb_first", 256'(wbf), 256'(1));
    chk("wb_rdaddr", 256'(rda), 256'(32'hA40));
    chk("wb_rdata", rd, mem_line(32'hA40));

    // 0x440 was the earlier victim
    access(1'b0, 32'h440, '0, '0, 1'b0, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("evicted440_nwb", 256'(n_wb), 256'(0));

    // Make 0xC40 dirty and steer PLRU onto it
    access(1'b1, 32'hC40, 32'hFFFF_FFFF, d, 1'b0, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("wmiss_nwb", 256'(n_wb), 256'(0));
    access(1'b0, 32'hA40, '0, '0, 1'b1, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    access(1'b0, 32'h640, '0, '0, 1'b1, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk_counters("steady");

    // Reset in the middle of a write-back
    mem_address = 32'hE40; mem_read = 1'b1;
    cyc = 0;
    #1;
    while (!pmem_write && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("midwb_started", 256'(pmem_write), 256'(1));
    chk("midwb_addr", 256'(pmem_address), 256'(32'hC40));
    #1 rst = 1'b1;
    #1;
    chk("midwb_pmem_write", 256'(pmem_write), 256'(0));
    chk("midwb_pmem_read", 256'(pmem_read), 256'(0));
    chk("midwb_mem_resp", 256'(mem_resp), 256'(0));
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_h = 0; exp_m = 0;
    @(negedge clk);
    chk_counters("postrst");
    access(1'b0, 32'h640, '0, '0, 1'b0, rd, n_wb, n_rd, wba, wbd, rda, wbf);
    chk("postrst_nwb", 256'(n_wb), 256'(0));
    chk("postrst_rdaddr", 256'(rda), 256'(32'h640));
    chk_counters("postrst_miss");

    // 8-way: nine tags in one set, the ninth evicts the first
    for (int t = 0; t < 9; t++) begin
      access8(32'h40 + 32'(t) * 32'h200, n_rd, n_wb, rda, hit8);
      chk("w8_fill_nrd", 256'(n_rd), 256'(1));
      chk("w8_fill_nwb", 256'(n_wb), 256'(0));
    end
    chk("w8_ninth_addr", 256'(rda), 256'(32'h1040));
    access8(32'h240, n_rd, n_wb, rda, hit8);
    chk("w8_tag1_hit", 256'(hit8), 256'(1));
    access8(32'hE40, n_rd, n_wb, rda, hit8);
    chk("w8_tag7_hit", 256'(hit8), 256'(1));
    access8(32'h40, n_rd, n_wb, rda, hit8);
    chk("w8_tag0_miss", 256'(hit8), 256'(0));
    chk("w8_tag0_rdaddr", 256'(rda), 256'(32'h40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
